// File: rtl/cnn_axi_pkg.sv
// Shared definitions for the CNN AXI read loaders: FSM state encoding,
// AXI AR-channel constants and beat geometry.
package cnn_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_FIN  = 2'd3
  } ifm_state_e;

  localparam logic [2:0] AXI_SIZE_32B   = 3'd5;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam int BEAT_BYTES = 32;
  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
  // Beats that fit in one 4 KB AXI page.
  localparam int PAGE_BEATS = 4096 / BEAT_BYTES;

endpackage

// File: rtl/ifm_burst_calc.sv
// Combinational burst sizing: the next burst is the smallest of the beats
// still to load, the configured burst cap and the beats left before the
// current address crosses a 4 KB page.
module ifm_burst_calc
  import cnn_axi_pkg::*;
#(
  parameter int REM_WIDTH = 20,
  parameter int LEN_WIDTH = 8,
  parameter int MAX_BURST = 128
) (
  input  logic [REM_WIDTH-1:0]    remaining,
  input  logic [11-BEAT_SHIFT:0]  page_beat,
  output logic [LEN_WIDTH:0]      burst_len
);

  localparam int LW1 = LEN_WIDTH + 1;
  localparam logic [LEN_WIDTH:0] MAX_L  = LW1'(MAX_BURST);
  localparam logic [LEN_WIDTH:0] PAGE_L = LW1'(PAGE_BEATS);

  logic [LEN_WIDTH:0] to_page;
  logic [LEN_WIDTH:0] cap;

  // Clamp the remaining count against the page boundary and the burst cap.
  always_comb begin
    to_page = PAGE_L - LW1'(page_beat);
    cap     = (to_page < MAX_L) ? to_page : MAX_L;
    if (remaining < REM_WIDTH'(cap)) begin
      burst_len = LW1'(remaining);
    end else begin
      burst_len = cap;
    end
  end

endmodule

// File: rtl/ifm_burst_loader.sv
// IFM burst loader: splits a DDR read of total_beats 32-byte beats into
// AXI INCR bursts (page- and cap-limited) and streams each returned beat
// into the IFM buffer one cycle after it is accepted.
// Optional build macro IFM_LOADER_RLAST_CHECK_EN: flag rlast that disagrees
// with the internal beat counter as an error.
module ifm_burst_loader
  import cnn_axi_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int AXI_WIDTH      = 256,
  parameter int ID_WIDTH       = 4,
  parameter int LEN_WIDTH      = 8,
  parameter int BUF_ADDR_WIDTH = 19,
  parameter int MAX_BURST      = 128
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     src_addr,
  input  logic [BUF_ADDR_WIDTH-1:0] buf_base,
  input  logic [BUF_ADDR_WIDTH:0]   total_beats,
  output logic [ID_WIDTH-1:0]       arid,
  output logic [ADDR_WIDTH-1:0]     araddr,
  output logic [LEN_WIDTH-1:0]      arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [AXI_WIDTH-1:0]      rdata,
  input  logic [1:0]                rresp,
  input  logic                      rlast,
  input  logic                      rvalid,
  output logic                      rready,
  output logic                      wr_en,
  output logic [BUF_ADDR_WIDTH-1:0] wr_addr,
  output logic [AXI_WIDTH-1:0]      wr_data,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int CNT_W = BUF_ADDR_WIDTH + 1;
  localparam int LW1   = LEN_WIDTH + 1;
  localparam logic [LEN_WIDTH:0] ONE_L = LW1'(1);

  ifm_state_e                state_q, state_d;
  logic                      run_q, run_d;
  logic [ADDR_WIDTH-1:0]     araddr_q, araddr_d;
  logic [LEN_WIDTH-1:0]      arlen_q, arlen_d;
  logic                      arvalid_q, arvalid_d;
  logic                      rready_q, rready_d;
  logic [CNT_W-1:0]          rem_q, rem_d;
  logic [LEN_WIDTH-1:0]      cnt_q, cnt_d;
  logic [BUF_ADDR_WIDTH-1:0] widx_q, widx_d;
  logic                      wr_en_q, wr_en_d;
  logic [BUF_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [AXI_WIDTH-1:0]      wr_data_q, wr_data_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;

  logic [LEN_WIDTH:0]        cur_len;
  logic [ADDR_WIDTH-1:0]     next_addr;
  logic [CNT_W-1:0]          calc_rem;
  logic [11-BEAT_SHIFT:0]    calc_page;
  logic [LEN_WIDTH:0]        calc_len;
  logic [LEN_WIDTH-1:0]      new_arlen;
  logic                      beat_ok;
  logic                      beat_last;
  logic                      rlast_err;

  // Length and address of the burst in flight, and where the next one starts.
  assign cur_len   = {1'b0, arlen_q} + ONE_L;
  assign next_addr = araddr_q + (ADDR_WIDTH'(cur_len) << BEAT_SHIFT);
  assign beat_ok   = rready_q && rvalid;
  assign beat_last = (cnt_q == arlen_q);

  // In IDLE the first burst is sized from the request; afterwards from
  // what is left once the current burst completes.
  assign calc_rem  = (state_q == ST_IDLE) ? total_beats : rem_q;
  assign calc_page = (state_q == ST_IDLE) ? src_addr[11:BEAT_SHIFT]
                                          : next_addr[11:BEAT_SHIFT];
  assign new_arlen = LEN_WIDTH'(calc_len - ONE_L);

  ifm_burst_calc #(
    .REM_WIDTH (CNT_W),
    .LEN_WIDTH (LEN_WIDTH),
    .MAX_BURST (MAX_BURST)
  ) u_calc (
    .remaining (calc_rem),
    .page_beat (calc_page),
    .burst_len (calc_len)
  );

`ifdef IFM_LOADER_RLAST_CHECK_EN
  assign rlast_err = beat_ok && (rlast != beat_last);
`else
  // rlast carries no information here; the beat counter alone ends a burst.
  logic unused_rlast;
  assign unused_rlast = rlast;
  assign rlast_err    = 1'b0;
`endif

  // Next-state and next-output logic for the loader FSM.
  always_comb begin
    state_d   = state_q;
    run_d     = 1'b1;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    widx_d    = widx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (run_q && start) begin
          err_d  = 1'b0;
          widx_d = buf_base;
          rem_d  = total_beats;
          if (total_beats == '0) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end else begin
            state_d   = ST_ADDR;
            busy_d    = 1'b1;
            arvalid_d = 1'b1;
            araddr_d  = src_addr;
            arlen_d   = new_arlen;
          end
        end
      end
      ST_ADDR: begin
        if (arvalid_q && arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          cnt_d     = '0;
          rem_d     = rem_q - CNT_W'(cur_len);
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (beat_ok) begin
          wr_en_d   = 1'b1;
          wr_data_d = rdata;
          wr_addr_d = widx_q;
          widx_d    = widx_q + BUF_ADDR_WIDTH'(1);
          cnt_d     = cnt_q + LEN_WIDTH'(1);
          if (rresp != 2'b00 || rlast_err) begin
            err_d = 1'b1;
          end
          if (beat_last) begin
            rready_d = 1'b0;
            if (rem_q != '0) begin
              state_d   = ST_ADDR;
              arvalid_d = 1'b1;
              araddr_d  = next_addr;
              arlen_d   = new_arlen;
            end
          end
        end else if (!rready_q) begin
          // Final write went out last cycle; report completion now.
          state_d = ST_FIN;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset clears everything at once, and
  // run_q holds off start for one edge after reset release.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= ST_IDLE;
      run_q     <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      rem_q     <= '0;
      cnt_q     <= '0;
      widx_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      widx_q    <= widx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign arid    = '0;
  assign araddr  = araddr_q;
  assign arlen   = arlen_q;
  assign arsize  = run_q ? AXI_SIZE_32B : 3'd0;
  assign arburst = run_q ? AXI_BURST_INCR : 2'd0;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_ifm_burst_loader.sv
// Bench for ifm_burst_loader: table of load requests replayed through an
// AXI slave model, with a write scoreboard and hand-written corner cases.
module tb_ifm_burst_loader;

  logic         ACLK = 1'b0;
  logic         ARESETN = 1'b0;
  logic         start = 1'b0;
  logic [31:0]  src_addr = '0;
  logic [18:0]  buf_base = '0;
  logic [19:0]  total_beats = '0;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready = 1'b0;
  logic [255:0] rdata = '0;
  logic [1:0]   rresp = '0;
  logic         rlast = 1'b0;
  logic         rvalid = 1'b0;
  logic         rready;
  logic         wr_en;
  logic [18:0]  wr_addr;
  logic [255:0] wr_data;
  logic         busy;
  logic         done;
  logic         err;

  ifm_burst_loader dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .src_addr(src_addr),
    .buf_base(buf_base), .total_beats(total_beats), .arid(arid),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done), .err(err)
  );

  always #5 ACLK = ~ACLK;

`ifdef IFM_LOADER_RLAST_CHECK_EN
  localparam bit RLAST_EN = 1'b1;
`else
  localparam bit RLAST_EN = 1'b0;
`endif

  typedef struct { logic [18:0] addr; logic [255:0] data; } wr_t;
  typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct {
    logic [31:0] src; logic [18:0] base; logic [19:0] total;
    int stall; bit tog; int errb; int flip; bit exp_err;
    int nar; logic [7:0] first_len; logic [7:0] last_len; logic [31:0] last_addr;
  } vec_t;

  wr_t exp_wr[$];
  ar_t exp_ar[$];
  int checks = 0;
  int failures = 0;
  int wr_count = 0;
  int done_count = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Write-port scoreboard and done counter, sampled on the falling edge.
  always @(negedge ACLK) begin
    if (ARESETN && done) done_count++;
    if (ARESETN && wr_en) begin
      wr_t e;
      wr_count++;
      if (exp_wr.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wr_unexpected actual_addr=%0h required=none", wr_addr);
      end else begin
        e = exp_wr.pop_front();
        check("wr_addr", wr_addr, e.addr);
        check("wr_data", wr_data, e.data);
      end
    end
  end

  task automatic wait_arvalid(output bit seen);
    seen = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(negedge ACLK);
      if (arvalid) begin seen = 1'b1; break; end
    end
    if (!seen) check("ar_timeout", 0, 1);
  endtask

  // Offer one R beat and hold it until rready takes it; record expectation.
  task automatic send_beat(input logic [18:0] wa, input logic [1:0] resp,
                           input logic last, output bit ok);
    logic [255:0] d;
    for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom();
    rdata = d; rresp = resp; rlast = last; rvalid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge ACLK);
      ok = rready;
      @(posedge ACLK);
      #1;
      if (ok) break;
    end
    if (ok) exp_wr.push_back('{wa, d});
    else check("r_timeout", 0, 1);
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
  endtask

  task automatic pulse_start(input logic [31:0] src, input logic [18:0] base, input logic [19:0] total);
    @(posedge ACLK);
    #1 start = 1'b1; src_addr = src; buf_base = base; total_beats = total;
    @(posedge ACLK);
    #1 start = 1'b0;
  endtask

  task automatic run_load(input vec_t v, output int n_ar, output logic [7:0] first_len,
                          output logic [7:0] last_len, output logic [31:0] last_addr);
    logic [31:0] a;
    int rem, len, nb, gidx, wr_before, done_before;
    ar_t it;
    bit seen, ok, stable;
    logic [31:0] cap_addr;
    logic [7:0] cap_len;
    exp_ar.delete();
    a = v.src; rem = int'(v.total);
    while (rem > 0) begin
      len = (rem > 128) ? 128 : rem;
      nb = (4096 - int'(a % 4096)) / 32;
      if (len > nb) len = nb;
      exp_ar.push_back('{a, 8'(len - 1)});
      a = a + 32'(len * 32);
      rem -= len;
    end
    n_ar = 0; first_len = '0; last_len = '0; last_addr = '0;
    wr_before = wr_count; done_before = done_count; gidx = 0;
    pulse_start(v.src, v.base, v.total);
    while (exp_ar.size() > 0) begin
      wait_arvalid(seen);
      if (!seen) return;
      it = exp_ar.pop_front();
      check("araddr", araddr, it.addr);
      check("arlen", arlen, it.len);
      check("arsize_arburst", {arsize, arburst}, {3'd5, 2'b01});
      cap_addr = araddr; cap_len = arlen; stable = 1'b1;
      if (n_ar == 0) first_len = arlen;
      last_len = arlen; last_addr = araddr; n_ar++;
      for (int s = 0; s < v.stall; s++) begin
        start = (s == 3);
        total_beats = (s == 3) ? 20'd1 : v.total;
        @(negedge ACLK);
        if (araddr !== cap_addr || arlen !== cap_len || !arvalid) stable = 1'b0;
      end
      start = 1'b0; total_beats = v.total;
      if (v.stall > 0) check("ar_stable", stable, 1);
      arready = 1'b1;
      @(posedge ACLK);
      #1 arready = 1'b0;
      for (int i = 0; i <= int'(cap_len); i++) begin
        if (v.tog) begin @(posedge ACLK); #1; end
        send_beat(v.base + 19'(gidx), (gidx == v.errb) ? 2'b10 : 2'b00,
                  (i == int'(cap_len)) ^ (gidx == v.flip), ok);
        if (!ok) return;
        gidx++;
      end
    end
    @(negedge ACLK);
    check("final_wr_en", wr_en, 1);
    check("done_not_early", done, 0);
    @(negedge ACLK);
    check("done_pulse", done, 1);
    check("busy_low_at_done", busy, 0);
    repeat (3) @(negedge ACLK);
    check("done_once", done_count - done_before, 1);
    check("wr_count", wr_count - wr_before, v.total);
    check("wr_queue_empty", exp_wr.size(), 0);
    check("err", err, v.exp_err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int n_ar;
    logic [7:0] fl, ll;
    logic [31:0] la;
    bit seen, ok, any_ar;
    int done_before;

    //          src         base       total stall tog errb flip exp_err    nar first last last_addr
    vecs[0] = '{32'h0,     19'h0,     20'd300, 0, 0, -1, -1, 1'b0,     3, 8'd127, 8'd43,  32'h2000};
    vecs[1] = '{32'hF80,   19'h100,   20'd10,  0, 0, -1, -1, 1'b0,     2, 8'd3,   8'd5,   32'h1000};
    vecs[2] = '{32'h12340, 19'h7FFFC, 20'd8,   0, 0, -1, -1, 1'b0,     1, 8'd7,   8'd7,   32'h12340};
    vecs[3] = '{32'h400,   19'h20,    20'd8,  20, 1, -1, -1, 1'b0,     1, 8'd7,   8'd7,   32'h400};
    vecs[4] = '{32'h800,   19'h0,     20'd4,   0, 0,  2, -1, 1'b1,     1, 8'd3,   8'd3,   32'h800};
    vecs[5] = '{32'h40,    19'h10,    20'd130, 0, 0, -1, -1, 1'b0,     2, 8'd125, 8'd3,   32'h1000};
    vecs[6] = '{32'hC00,   19'h0,     20'd4,   0, 0, -1,  2, RLAST_EN, 1, 8'd3,   8'd3,   32'hC00};

    repeat (2) @(negedge ACLK);
    check("reset_outputs", {arvalid, rready, wr_en, busy, done, err, arsize, arburst, arid, araddr, arlen, wr_addr}, 0);
    check("reset_wr_data", wr_data, 0);
    ARESETN = 1'b1;

    for (int v = 0; v < 7; v++) begin
      run_load(vecs[v], n_ar, fl, ll, la);
      check($sformatf("v%0d_n_ar", v), n_ar, vecs[v].nar);
      check($sformatf("v%0d_first_arlen", v), fl, vecs[v].first_len);
      check($sformatf("v%0d_last_arlen", v), ll, vecs[v].last_len);
      check($sformatf("v%0d_last_araddr", v), la, vecs[v].last_addr);
    end

    // Zero-length request: done on the cycle after start, no AR at all.
    done_before = done_count;
    @(posedge ACLK);
    #1 start = 1'b1; total_beats = 20'd0;
    @(posedge ACLK);
    #1 start = 1'b0;
    @(negedge ACLK);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    any_ar = 1'b0;
    repeat (5) begin @(negedge ACLK); if (arvalid) any_ar = 1'b1; end
    check("zero_no_arvalid", any_ar, 0);
    check("zero_done_once", done_count - done_before, 1);

    // Reset in the middle of a 16-beat burst, after five beats.
    pulse_start(32'h200, 19'h0, 20'd16);
    wait_arvalid(seen);
    arready = 1'b1;
    @(posedge ACLK);
    #1 arready = 1'b0;
    for (int i = 0; i < 5; i++) send_beat(19'(i), 2'b00, 1'b0, ok);
    @(negedge ACLK);
    #1 ARESETN = 1'b0;
    #1;
    check("midreset_outputs", {arvalid, rready, wr_en, busy, done, err, arsize, arburst, arid, araddr, arlen, wr_addr}, 0);
    check("midreset_wr_data", wr_data, 0);
    done_before = done_count;
    repeat (4) @(negedge ACLK);
    check("midreset_no_done", done_count - done_before, 0);
    check("midreset_wr_queue", exp_wr.size(), 0);
    exp_wr.delete();
    ARESETN = 1'b1;
    // Start is raised right after the first edge following release.
    run_load('{32'h200, 19'h0, 20'd16, 0, 0, -1, -1, 1'b0, 1, 8'd15, 8'd15, 32'h200}, n_ar, fl, ll, la);
    check("post_reset_n_ar", n_ar, 1);
    check("post_reset_arlen", fl, 8'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
